// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL lock sequencer.
// Default timings assume a 50 MHz refclk.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 100;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int DEF_CNT_W         = 8;

  // The timer must reach (largest terminal count - 1); never narrower than 1 bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by the
// synchronous active-low reset of the destination domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock detection and stability qualification before
// asserting clk_ready; retries on timeout or lock loss and tracks events.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int TMR_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             locked_s;
  logic             timeout_ev;
  logic             loss_ev;
  logic             run_entry;

  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
  logic             fault_q, fault_d;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Lock loss and timeout outrank relock_req, which outranks normal progress.
  always_comb begin
    state_d    = state_q;
    timeout_ev = 1'b0;
    loss_ev    = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (timer_q == TIMEOUT_LAST) begin
          state_d    = PLL_RST;
          timeout_ev = 1'b1;
        end else if (relock_req) begin
          state_d = PLL_RST;
        end else if (locked_s) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s)                    state_d = WAIT_LOCK;
        else if (relock_req)              state_d = PLL_RST;
        else if (timer_q == STABLE_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PLL_RST;
          loss_ev = 1'b1;
        end else if (relock_req) begin
          state_d = PLL_RST;
        end
      end
      default: state_d = PLL_RST;
    endcase

    run_entry = (state_q == STABLE) && (state_d == RUN);

    // Timer is idle in RUN so it never wraps while the clock is in use.
    if (state_d != state_q)  timer_d = '0;
    else if (state_q == RUN) timer_d = timer_q;
    else                     timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    fault_d     = fault_q;
    if (loss_ev && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + 1'b1;
    if (timeout_ev) begin
      if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + 1'b1;
      if ((int'(retry_cnt_q) + 1) >= MAX_RETRIES) fault_d = 1'b1;
    end else if (run_entry) begin
      retry_cnt_d = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_cnt_q  <= '0;
      retry_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      loss_cnt_q  <= loss_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst       = (state_q == PLL_RST);
  assign clk_ready     = (state_q == RUN);
  assign fault         = fault_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign retry_cnt     = retry_cnt_q;

endmodule
